// File: rtl/uart_dbg_ctrl_if.sv
// uart_dbg_ctrl_if: UART byte stream, OBI manager port and core control signals of uart_dbg_ctrl.
// master is the controller side, slave is the UART/bus/core side.
interface uart_dbg_ctrl_if;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;
    logic        eoc_i;
    logic [31:0] boot_addr_o;
    logic        fetch_en_o;

    modport master (
        input  rx_data_i, rx_valid_i, tx_ready_i, obi_gnt_i, obi_rvalid_i,
               obi_rdata_i, obi_err_i, eoc_i,
        output rx_ready_o, tx_data_o, tx_valid_o, obi_req_o, obi_addr_o,
               obi_we_o, obi_be_o, obi_wdata_o, boot_addr_o, fetch_en_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, tx_ready_i, obi_gnt_i, obi_rvalid_i,
               obi_rdata_i, obi_err_i, eoc_i,
        input  rx_ready_o, tx_data_o, tx_valid_o, obi_req_o, obi_addr_o,
               obi_we_o, obi_be_o, obi_wdata_o, boot_addr_o, fetch_en_o
    );
endinterface

// File: rtl/uart_dbg_ctrl.sv
// uart_dbg_ctrl: host debug command sequencer (READ/WRITE/EXEC) from a UART byte stream onto one OBI port.
// Optional inter-byte timeout in the receive states is enabled by defining UART_DBG_TIMEOUT_EN.
module uart_dbg_ctrl #(
    parameter int unsigned LenWidth      = 16,
    parameter int unsigned TimeoutCycles = 1_000_000
) (
    input logic             clk_i,
    input logic             rst_ni,
    uart_dbg_ctrl_if.master bus
);
    localparam logic [7:0] CMD_READ  = 8'h11;
    localparam logic [7:0] CMD_WRITE = 8'h12;
    localparam logic [7:0] CMD_EXEC  = 8'h13;
    localparam logic [7:0] BYTE_ACK  = 8'h06;
    localparam logic [7:0] BYTE_EOT  = 8'h04;
    localparam logic [7:0] BYTE_EOC  = 8'h14;
    localparam logic [7:0] BYTE_NAK  = 8'h15;

    typedef enum logic [3:0] {
        IDLE, RX_ADDR, RX_LEN, RX_WDATA, BUS_REQ, BUS_WAIT, TX_DATA, TX_END, EXEC
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          cmd_q;
    logic [31:0]         addr_q;
    logic [LenWidth-1:0] len_q;
    logic [1:0]          cnt_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic [7:0]          tx_q;
    logic                err_q;
    logic                ack_lead_q;
    logic                eoc_q;
    logic                eoc_pend_q;
    logic [31:0]         boot_q;
    logic                fetch_q;
    logic                live_q;

    logic                rx_ready, rx_hs, tx_valid, tx_hs, eoc_take, is_cmd;
    logic                last_word, err_n, timeout;
    logic [LenWidth-1:0] len_new;

    assign rx_ready  = live_q && (((state_q == IDLE) && !eoc_pend_q) ||
                                  (state_q inside {RX_ADDR, RX_LEN, RX_WDATA}));
    assign rx_hs     = bus.rx_valid_i && rx_ready;
    assign tx_valid  = state_q inside {TX_DATA, TX_END};
    assign tx_hs     = tx_valid && bus.tx_ready_i;
    assign eoc_take  = (state_q == IDLE) && live_q && eoc_pend_q;
    assign is_cmd    = bus.rx_data_i inside {CMD_READ, CMD_WRITE, CMD_EXEC};
    assign last_word = (len_q == LenWidth'(1));
    assign err_n     = err_q || bus.obi_err_i;
    assign len_new   = LenWidth'({bus.rx_data_i, len_q[7:0]});

`ifdef UART_DBG_TIMEOUT_EN
    localparam int unsigned ToWidth = $clog2(TimeoutCycles + 1);
    logic [ToWidth-1:0] to_cnt_q;
    logic               in_rx;

    assign in_rx   = state_q inside {RX_ADDR, RX_LEN, RX_WDATA};
    assign timeout = in_rx && !rx_hs && (to_cnt_q == ToWidth'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
        end else if (in_rx && !rx_hs && !timeout) begin
            to_cnt_q <= to_cnt_q + ToWidth'(1);
        end else begin
            to_cnt_q <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            live_q     <= 1'b0;
            eoc_q      <= 1'b0;
            eoc_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            live_q     <= 1'b1;
            eoc_q      <= bus.eoc_i;
            eoc_pend_q <= (eoc_pend_q && !eoc_take) || (bus.eoc_i && !eoc_q);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (eoc_take) begin
                    state_d = TX_END;
                end else if (rx_hs && is_cmd) begin
                    state_d = RX_ADDR;
                end
            end
            RX_ADDR: begin
                if (rx_hs && (cnt_q == 2'd3)) begin
                    state_d = (cmd_q == CMD_EXEC) ? EXEC : RX_LEN;
                end
            end
            RX_LEN: begin
                if (rx_hs && (cnt_q == 2'd1)) begin
                    state_d = ((cmd_q == CMD_WRITE) && (len_new != '0)) ? RX_WDATA : TX_END;
                end
            end
            RX_WDATA: begin
                if (rx_hs && (cnt_q == 2'd3)) begin
                    state_d = BUS_REQ;
                end
            end
            BUS_REQ: begin
                if (bus.obi_gnt_i) begin
                    state_d = BUS_WAIT;
                end
            end
            BUS_WAIT: begin
                if (bus.obi_rvalid_i) begin
                    if (cmd_q == CMD_WRITE) begin
                        state_d = last_word ? TX_END : RX_WDATA;
                    end else begin
                        state_d = TX_DATA;
                    end
                end
            end
            TX_DATA: begin
                if (tx_hs && (cnt_q == 2'd3)) begin
                    state_d = last_word ? TX_END : BUS_REQ;
                end
            end
            TX_END: begin
                // A READ's leading ACK continues into the data phase, or straight to EOT when len==0.
                if (tx_hs) begin
                    if (!ack_lead_q) begin
                        state_d = IDLE;
                    end else if (len_q != '0) begin
                        state_d = BUS_REQ;
                    end
                end
            end
            EXEC:    state_d = TX_END;
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            tx_q       <= '0;
            err_q      <= 1'b0;
            ack_lead_q <= 1'b0;
            boot_q     <= '0;
            fetch_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    err_q <= 1'b0;
                    if (eoc_take) begin
                        tx_q       <= BYTE_EOC;
                        ack_lead_q <= 1'b0;
                    end else if (rx_hs) begin
                        cmd_q <= bus.rx_data_i;
                        cnt_q <= '0;
                    end
                end
                RX_ADDR: begin
                    if (rx_hs) begin
                        addr_q <= {bus.rx_data_i, addr_q[31:8]};
                        cnt_q  <= cnt_q + 2'd1;
                    end
                end
                RX_LEN: begin
                    if (rx_hs) begin
                        if (cnt_q == 2'd0) begin
                            len_q <= LenWidth'(bus.rx_data_i);
                            cnt_q <= 2'd1;
                        end else begin
                            len_q      <= len_new;
                            cnt_q      <= '0;
                            tx_q       <= BYTE_ACK;
                            ack_lead_q <= (cmd_q == CMD_READ);
                        end
                    end
                end
                RX_WDATA: begin
                    if (rx_hs) begin
                        wdata_q <= {bus.rx_data_i, wdata_q[31:8]};
                        cnt_q   <= cnt_q + 2'd1;
                    end
                end
                BUS_WAIT: begin
                    if (bus.obi_rvalid_i) begin
                        err_q <= err_n;
                        if (cmd_q == CMD_WRITE) begin
                            len_q  <= len_q - LenWidth'(1);
                            addr_q <= addr_q + 32'd4;
                            tx_q   <= err_n ? BYTE_NAK : BYTE_ACK;
                        end else begin
                            rdata_q <= err_n ? '0 : bus.obi_rdata_i;
                        end
                    end
                end
                TX_DATA: begin
                    if (tx_hs) begin
                        rdata_q <= {8'h00, rdata_q[31:8]};
                        cnt_q   <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            len_q  <= len_q - LenWidth'(1);
                            addr_q <= addr_q + 32'd4;
                            tx_q   <= err_q ? BYTE_NAK : BYTE_EOT;
                        end
                    end
                end
                TX_END: begin
                    if (tx_hs && ack_lead_q) begin
                        ack_lead_q <= 1'b0;
                        tx_q       <= BYTE_EOT;
                    end
                end
                EXEC: begin
                    boot_q     <= addr_q;
                    fetch_q    <= 1'b1;
                    tx_q       <= BYTE_ACK;
                    ack_lead_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready_o  = rx_ready;
    assign bus.tx_valid_o  = tx_valid;
    assign bus.tx_data_o   = (state_q == TX_DATA) ? rdata_q[7:0] :
                             (state_q == TX_END)  ? tx_q : 8'h00;
    assign bus.obi_req_o   = (state_q == BUS_REQ);
    assign bus.obi_addr_o  = {addr_q[31:2], 2'b00};
    assign bus.obi_we_o    = (state_q == BUS_REQ) && (cmd_q == CMD_WRITE);
    assign bus.obi_be_o    = 4'hF;
    assign bus.obi_wdata_o = wdata_q;
    assign bus.boot_addr_o = boot_q;
    assign bus.fetch_en_o  = fetch_q;
endmodule

// File: tb/tb_uart_dbg_ctrl.sv
// tb_uart_dbg_ctrl: random and directed host commands checked against a byte/word-level protocol model.
// Define UART_DBG_TIMEOUT_EN to also exercise the inter-byte timeout with a short TimeoutCycles.
`timescale 1ns/1ps
module tb_uart_dbg_ctrl;
`ifdef UART_DBG_TIMEOUT_EN
    localparam int unsigned TO = 200;
`else
    localparam int unsigned TO = 1_000_000;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_dbg_ctrl_if intf ();

    uart_dbg_ctrl #(.LenWidth(16), .TimeoutCycles(TO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (intf)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    bus_t        bus_log[$];
    logic [7:0]  tx_log[$];
    logic [31:0] wq[$];
    int          err_txn = -1;
    int          txn_idx = 0;
    int          gnt_min = 0;
    int          tx_stall_pct = 25;
    int          stab_viol = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // OBI subordinate: random grant delay, one response 1..3 cycles after grant.
    bit          outstanding = 0;
    int          rsp_wait = 0;
    int          req_wait = 0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    bit          held_valid = 0;
    bus_t        held;

    always @(negedge clk) begin
        if (!rst_n) begin
            intf.obi_gnt_i    = 1'b0;
            intf.obi_rvalid_i = 1'b0;
            intf.obi_rdata_i  = '0;
            intf.obi_err_i    = 1'b0;
            outstanding       = 0;
            req_wait          = 0;
            held_valid        = 0;
        end else begin
            intf.obi_gnt_i    = 1'b0;
            intf.obi_rvalid_i = 1'b0;
            intf.obi_err_i    = 1'b0;
            if (held_valid && (!intf.obi_req_o || intf.obi_addr_o !== held.addr ||
                               intf.obi_we_o !== held.we || intf.obi_wdata_o !== held.wdata))
                stab_viol++;
            held_valid = 0;
            if (intf.obi_req_o && intf.obi_be_o !== 4'hF) stab_viol++;
            if (outstanding) begin
                if (intf.obi_req_o) stab_viol++;
                if (rsp_wait == 0) begin
                    intf.obi_rvalid_i = 1'b1;
                    intf.obi_rdata_i  = rsp_data;
                    intf.obi_err_i    = rsp_err;
                    outstanding       = 0;
                end else begin
                    rsp_wait--;
                end
            end else if (intf.obi_req_o) begin
                if (req_wait >= gnt_min && $urandom_range(0, 2) != 0) begin
                    bus_t e;
                    e.addr = intf.obi_addr_o;
                    e.we = intf.obi_we_o;
                    e.wdata = intf.obi_wdata_o;
                    bus_log.push_back(e);
                    intf.obi_gnt_i = 1'b1;
                    rsp_err = (txn_idx == err_txn);
                    if (e.we && !rsp_err) mem[e.addr] = e.wdata;
                    rsp_data = e.we ? 32'h0 : (mem.exists(e.addr) ? mem[e.addr] : init_word(e.addr));
                    rsp_wait = $urandom_range(0, 2);
                    outstanding = 1;
                    txn_idx++;
                    req_wait = 0;
                end else begin
                    req_wait++;
                    held_valid = 1;
                    held.addr = intf.obi_addr_o;
                    held.we = intf.obi_we_o;
                    held.wdata = intf.obi_wdata_o;
                end
            end
        end
    end

    // UART tx sink with random back-pressure; a stalled byte must stay valid and unchanged.
    bit         tx_held = 0;
    logic [7:0] tx_held_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            intf.tx_ready_i = 1'b0;
            tx_held = 0;
        end else begin
            if (tx_held && (!intf.tx_valid_o || intf.tx_data_o !== tx_held_data)) stab_viol++;
            intf.tx_ready_i = ($urandom_range(0, 99) >= tx_stall_pct);
            if (intf.tx_valid_o && intf.tx_ready_i) begin
                tx_log.push_back(intf.tx_data_o);
                tx_held = 0;
            end else begin
                tx_held = intf.tx_valid_o;
                tx_held_data = intf.tx_data_o;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        intf.rx_valid_i = 1'b1;
        intf.rx_data_i  = b;
        while (!intf.rx_ready_o && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) check_eq("rx_accept_wait", 32'(n), 32'd0);
        @(negedge clk);
        intf.rx_valid_i = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_tx(input int n, input string tag);
        int k = 0;
        while (tx_log.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) check_eq({tag, "_tx_wait"}, 32'(tx_log.size()), 32'(n));
    endtask

    task automatic run_cmd(input logic [7:0] cmd, input logic [31:0] addr, input int len,
                           input int err_w, input bit eoc_tail, input string tag);
        logic [7:0]  exp_tx[$];
        bus_t        exp_bus[$];
        bus_t        e;
        logic [31:0] w;
        logic [15:0] l16;
        bit          bad;
        tx_log.delete();
        bus_log.delete();
        txn_idx = 0;
        err_txn = err_w;
        l16 = 16'(len);
        bad = (err_w >= 0) && (err_w < len);
        if (cmd == 8'h11) exp_tx.push_back(8'h06);
        for (int i = 0; i < len; i++) begin
            e.addr  = (addr & 32'hFFFF_FFFC) + 32'(4 * i);
            e.we    = (cmd == 8'h12);
            e.wdata = e.we ? wq[i] : 32'h0;
            exp_bus.push_back(e);
            if (e.we) begin
                if (i != err_w) ref_mem[e.addr] = wq[i];
            end else begin
                w = (err_w >= 0 && i >= err_w) ? 32'h0 : ref_read(e.addr);
                for (int k = 0; k < 4; k++) exp_tx.push_back(w[8*k +: 8]);
            end
        end
        if (cmd == 8'h11) exp_tx.push_back(bad ? 8'h15 : 8'h04);
        else exp_tx.push_back(bad ? 8'h15 : 8'h06);
        if (eoc_tail) exp_tx.push_back(8'h14);

        send_byte(cmd);
        send_word(addr);
        send_byte(l16[7:0]);
        send_byte(l16[15:8]);
        if (cmd == 8'h12) for (int i = 0; i < len; i++) send_word(wq[i]);
        wait_tx(exp_tx.size(), tag);
        repeat (8) @(negedge clk);

        check_eq({tag, "_tx_count"}, 32'(tx_log.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            check_eq($sformatf("%s_tx%0d", tag, i), 32'(tx_log[i]), 32'(exp_tx[i]));
        check_eq({tag, "_bus_count"}, 32'(bus_log.size()), 32'(exp_bus.size()));
        for (int i = 0; i < exp_bus.size() && i < bus_log.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), bus_log[i].addr, exp_bus[i].addr);
            check_eq($sformatf("%s_we%0d", tag, i), 32'(bus_log[i].we), 32'(exp_bus[i].we));
            if (exp_bus[i].we)
                check_eq($sformatf("%s_wdata%0d", tag, i), bus_log[i].wdata, exp_bus[i].wdata);
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        intf.rx_valid_i = 1'b0;
        intf.rx_data_i  = 8'h00;
        intf.eoc_i      = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_valid", 32'(intf.tx_valid_o), 0);
        check_eq("rst_rx_ready", 32'(intf.rx_ready_o), 0);
        check_eq("rst_req", 32'(intf.obi_req_o), 0);
        check_eq("rst_fetch_en", 32'(intf.fetch_en_o), 0);
        check_eq("rst_boot_addr", intf.boot_addr_o, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // directed examples
        wq = '{32'h1234_5678, 32'hDEAD_BEEF};
        run_cmd(8'h12, 32'h0000_0010, 2, -1, 0, "wr_ex");
        check_eq("mem_10", mem[32'h10], 32'h1234_5678);
        check_eq("mem_14", mem[32'h14], 32'hDEAD_BEEF);
        run_cmd(8'h11, 32'h0000_0010, 2, -1, 0, "rd_ex");
        run_cmd(8'h11, 32'hFFFF_FFFC, 2, -1, 0, "rd_wrap");
        run_cmd(8'h11, 32'h0000_0040, 1, 0, 0, "rd_err");
        run_cmd(8'h11, 32'h0000_0020, 0, -1, 0, "rd_len0");
        run_cmd(8'h12, 32'h0000_0020, 0, -1, 0, "wr_len0");
        wq = '{32'hA1A2_A3A4, 32'hB1B2_B3B4, 32'hC1C2_C3C4};
        run_cmd(8'h12, 32'h0000_0103, 3, 1, 0, "wr_err");

        // unknown command byte is swallowed, next command parses
        tx_log.delete();
        send_byte(8'hA5);
        repeat (5) @(negedge clk);
        check_eq("unknown_no_tx", 32'(tx_log.size()), 0);
        run_cmd(8'h11, 32'h0000_0104, 1, -1, 0, "rd_after_unk");

        // EXEC then a single EOC on a held eoc_i
        tx_log.delete();
        send_byte(8'h13);
        send_word(32'h0000_0080);
        wait_tx(1, "exec");
        check_eq("exec_ack", 32'(tx_log.size() > 0 ? tx_log[0] : 8'hFF), 32'h06);
        check_eq("exec_boot", intf.boot_addr_o, 32'h80);
        check_eq("exec_fetch", 32'(intf.fetch_en_o), 1);
        tx_log.delete();
        intf.eoc_i = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("eoc_count", 32'(tx_log.size()), 1);
        check_eq("eoc_byte", 32'(tx_log.size() > 0 ? tx_log[0] : 8'hFF), 32'h14);
        intf.eoc_i = 1'b0;
        repeat (3) @(negedge clk);

        // two EOC edges during a busy READ merge into one EOC sent after EOT
        fork
            run_cmd(8'h11, 32'h0000_0200, 3, -1, 1, "rd_eoc");
            begin
                int k = 0;
                @(negedge clk);
                while (tx_log.size() < 1 && k < 3000) begin
                    @(negedge clk);
                    k++;
                end
                intf.eoc_i = 1'b1;
                @(negedge clk);
                intf.eoc_i = 1'b0;
                @(negedge clk);
                intf.eoc_i = 1'b1;
            end
        join
        intf.eoc_i = 1'b0;
        repeat (3) @(negedge clk);

        // long grant stall and heavy tx back-pressure
        gnt_min = 50;
        tx_stall_pct = 90;
        stab_viol = 0;
        run_cmd(8'h11, 32'h0000_0010, 2, -1, 0, "rd_stall");
        wq = '{32'h0BAD_F00D};
        run_cmd(8'h12, 32'h0000_0300, 1, -1, 0, "wr_stall");
        check_eq("stall_stable", 32'(stab_viol), 0);
        gnt_min = 0;

        // randomized commands against the model
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a;
            int len, ew;
            bit is_wr;
            is_wr = $urandom_range(0, 1) != 0;
            len = $urandom_range(0, 4);
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                            : 32'h1000 + 32'($urandom_range(0, 63));
            ew = (len > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
            tx_stall_pct = $urandom_range(0, 60);
            wq.delete();
            for (int i = 0; i < len; i++) wq.push_back($urandom);
            run_cmd(is_wr ? 8'h12 : 8'h11, a, len, ew, 0, $sformatf("rnd%0d", n));
        end
        tx_stall_pct = 25;

`ifdef UART_DBG_TIMEOUT_EN
        // partial WRITE header then silence: abort with no response
        tx_log.delete();
        bus_log.delete();
        send_byte(8'h12);
        send_byte(8'h00);
        repeat (TO + 20) @(negedge clk);
        check_eq("to_no_tx", 32'(tx_log.size()), 0);
        check_eq("to_no_bus", 32'(bus_log.size()), 0);
        run_cmd(8'h11, 32'h0000_0010, 1, -1, 0, "rd_after_to");
`endif

        // reset in the middle of a READ abandons everything
        tx_log.delete();
        send_byte(8'h11);
        send_word(32'h0000_0400);
        send_byte(8'h04);
        send_byte(8'h00);
        wait_tx(2, "mid_rst");
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("mrst_tx_valid", 32'(intf.tx_valid_o), 0);
        check_eq("mrst_req", 32'(intf.obi_req_o), 0);
        check_eq("mrst_fetch_en", 32'(intf.fetch_en_o), 0);
        check_eq("mrst_boot_addr", intf.boot_addr_o, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_cmd(8'h11, 32'h0000_0010, 2, -1, 0, "rd_after_rst");

        check_eq("final_stable", 32'(stab_viol), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
